axi_write_sequencer: RTL

Controller for the single-beat-address AXI4 write path. It owns the slave AW/W/B channels of a 4 KB AXI4 register window and checks each AW burst. Legal bursts are forwarded to the downstream address counter, and each counter-generated beat address is paired with its W data beat to drive a flat register-write port. It then issues one B response per burst. Illegal bursts are never forwarded: their data is drained and the burst is answered with SLVERR.

---
 rtl/axi_write_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_write_sequencer.sv
// rtl/axi_write_sequencer.sv - AXI4 write-path sequencer: AW burst check, beat/address pairing, B response
module axi_write_sequencer #(
  localparam int ADDR_WIDTH = 12,
  localparam int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // AW channel from master
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // W channel from master
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // B channel to master
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // AW forward to the address counter
  output logic [ADDR_WIDTH-1:0]   c_awaddr,
  output logic [7:0]              c_awlen,
  output logic [2:0]              c_awsize,
  output logic [1:0]              c_awburst,
  output logic                    c_awvalid,
  input  logic                    c_awready,
  // Per-beat address stream from the counter
  input  logic [ADDR_WIDTH-1:0]   c_addr_data,
  input  logic                    c_addr_valid,
  output logic                    c_addr_ready,
  // Flat register-write port
  output logic                    o_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_wr_strb,
  output logic [7:0]              o_err_count
);

  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH:0] WINDOW_END  = 13'd4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              len_q, len_d;
  logic [8:0]              count_q, count_d;
  logic                    wlast_err_q, wlast_err_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH/8-1:0] wr_strb_q, wr_strb_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [ADDR_WIDTH:0]     burst_end;
  logic                    aw_err;
  logic                    last_beat;

  // One bit of headroom so a burst ending exactly at the window top stays legal
  assign burst_end = {1'b0, s_awaddr} + ({4'b0000, {1'b0, s_awlen} + 9'd1} << 2);

  assign aw_err = (s_awburst != 2'b01)
                | (s_awsize != 3'd2)
                | (s_awaddr[1:0] != 2'b00)
                | (burst_end > WINDOW_END);

  assign last_beat = (count_q == {1'b0, len_q});

  assign c_awaddr  = s_awaddr;
  assign c_awlen   = s_awlen;
  assign c_awsize  = s_awsize;
  assign c_awburst = s_awburst;

  assign s_bvalid    = (state_q == RESP);
  assign s_bresp     = bresp_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_wr_strb   = wr_strb_q;
  assign o_err_count = err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      wlast_err_q <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      wlast_err_q <= wlast_err_d;
      bresp_q     <= bresp_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    wlast_err_d  = wlast_err_q;
    bresp_d      = bresp_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_strb_d    = wr_strb_q;
    err_cnt_d    = err_cnt_q;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    c_awvalid    = 1'b0;
    c_addr_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (aw_err) begin
          // Illegal bursts never reach the counter; accept and drain them locally
          s_awready = 1'b1;
          if (s_awvalid) begin
            len_d       = s_awlen;
            count_d     = '0;
            wlast_err_d = 1'b0;
            state_d     = DRAIN;
          end
        end else begin
          c_awvalid = s_awvalid;
          s_awready = c_awready;
          if (s_awvalid && c_awready) begin
            len_d       = s_awlen;
            count_d     = '0;
            wlast_err_d = 1'b0;
            state_d     = DATA;
          end
        end
      end

      DATA: begin
        s_wready     = c_addr_valid;
        c_addr_ready = s_wvalid;
        if (s_wvalid && c_addr_valid) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = c_addr_data;
          wr_data_d   = s_wdata;
          wr_strb_d   = s_wstrb;
          wlast_err_d = wlast_err_q | (s_wlast != last_beat);
          count_d     = count_q + 9'd1;
          // The beat count, not WLAST, ends the burst
          if (last_beat) begin
            state_d = RESP;
            bresp_d = wlast_err_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end

      DRAIN: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          count_d = count_q + 9'd1;
          if (last_beat) begin
            state_d = RESP;
            bresp_d = RESP_SLVERR;
          end
        end
      end

      RESP: begin
        if (s_bready) begin
          state_d = IDLE;
          if ((bresp_q == RESP_SLVERR) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
